load_store_unit: RTL

- Sits directly upstream of the 64-bit word-addressed data memory.
- Converts RV64 load/store requests (LB/LH/LW/LD/LBU/LHU/LWU, SB/SH/SW/SD) into word-aligned memory accesses.
- Loads: byte-lane extraction plus sign/zero extension. Sub-word stores: read-modify-write.
- Detects misaligned, out-of-range and illegal-funct3 requests and returns them as faults without touching memory.

---
 rtl/load_store_unit_if.sv | 31 +++
 rtl/load_store_unit.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/load_store_unit_if.sv
// Request/response and data-memory bus bundle for load_store_unit.
// slave  : the load/store unit side (takes requests, drives memory).
// master : the requester/memory side (testbench or core + data RAM).
interface load_store_unit_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_store;
    logic [2:0]  req_funct3;
    logic [63:0] req_addr;
    logic [63:0] req_wdata;
    logic        resp_valid;
    logic [63:0] resp_rdata;
    logic        resp_fault;
    logic        mem_read;
    logic        mem_write;
    logic [63:0] mem_addr;
    logic [63:0] mem_wdata;
    logic [63:0] mem_rdata;

    modport slave (
        input  req_valid, req_store, req_funct3, req_addr, req_wdata, mem_rdata,
        output req_ready, resp_valid, resp_rdata, resp_fault,
               mem_read, mem_write, mem_addr, mem_wdata
    );

    modport master (
        output req_valid, req_store, req_funct3, req_addr, req_wdata, mem_rdata,
        input  req_ready, resp_valid, resp_rdata, resp_fault,
               mem_read, mem_write, mem_addr, mem_wdata
    );
endinterface

// File: rtl/load_store_unit.sv
// RV64 load/store unit in front of a 64-bit word-addressed data memory.
// Loads extract and extend a byte lane; sub-word stores do read-modify-write;
// misaligned, out-of-range and illegal-funct3 requests fault without a memory access.
// Optional: define LSU_FAULT_COUNT_EN to add the saturating fault_count output.
module load_store_unit #(
    parameter int MEM_BYTES = 8192
) (
    input  logic                   clk,
    input  logic                   rst_n,
`ifdef LSU_FAULT_COUNT_EN
    output logic [15:0]            fault_count,
`endif
    load_store_unit_if.slave       bus
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_MERGE = 3'd2,
        ST_WRITE = 3'd3,
        ST_RESP  = 3'd4
    } state_t;

    state_t      r_state;
    state_t      w_state_next;
    logic [2:0]  r_funct3;
    logic [63:0] r_addr;
    logic [63:0] r_wdata;
    logic [63:0] r_merged;
    logic [63:0] r_rdata;
    logic        r_fault;

    logic        w_accept;
    logic        w_misaligned;
    logic        w_illegal;
    logic        w_range;
    logic        w_fault;
    logic [63:0] w_shift;
    logic [63:0] w_load_ext;
    logic [63:0] w_wdata_shift;
    logic [7:0]  w_size_mask;
    logic [7:0]  w_lane_mask;
    logic [63:0] w_merged;

    assign w_accept = bus.req_valid && (r_state == ST_IDLE);

    // Request checks evaluated on the incoming (not yet latched) fields.
    always_comb begin
        w_misaligned = 1'b0;
        case (bus.req_funct3[1:0])
            2'b01:   w_misaligned = bus.req_addr[0];
            2'b10:   w_misaligned = (bus.req_addr[1:0] != 2'b00);
            2'b11:   w_misaligned = (bus.req_addr[2:0] != 3'b000);
            default: w_misaligned = 1'b0;
        endcase
    end
    assign w_illegal = bus.req_store ? bus.req_funct3[2] : (bus.req_funct3 == 3'b111);
    assign w_range   = (bus.req_addr >= 64'(MEM_BYTES));
    assign w_fault   = w_misaligned || w_illegal || w_range;

    // Load path: bring the addressed lane down to bit 0, then extend.
    assign w_shift = bus.mem_rdata >> {r_addr[2:0], 3'b000};
    always_comb begin
        w_load_ext = 64'd0;
        case (r_funct3)
            3'b000:  w_load_ext = {{56{w_shift[7]}},  w_shift[7:0]};
            3'b001:  w_load_ext = {{48{w_shift[15]}}, w_shift[15:0]};
            3'b010:  w_load_ext = {{32{w_shift[31]}}, w_shift[31:0]};
            3'b011:  w_load_ext = w_shift;
            3'b100:  w_load_ext = {56'd0, w_shift[7:0]};
            3'b101:  w_load_ext = {48'd0, w_shift[15:0]};
            3'b110:  w_load_ext = {32'd0, w_shift[31:0]};
            default: w_load_ext = 64'd0;
        endcase
    end

    // Store merge: lanes covered by the access take store data, others keep memory data.
    always_comb begin
        w_size_mask = 8'h01;
        case (r_funct3[1:0])
            2'b00:   w_size_mask = 8'h01;
            2'b01:   w_size_mask = 8'h03;
            2'b10:   w_size_mask = 8'h0F;
            default: w_size_mask = 8'hFF;
        endcase
    end
    assign w_lane_mask   = w_size_mask << r_addr[2:0];
    assign w_wdata_shift = r_wdata << {r_addr[2:0], 3'b000};

    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_lane
            assign w_merged[gi*8 +: 8] = w_lane_mask[gi] ? w_wdata_shift[gi*8 +: 8]
                                                         : bus.mem_rdata[gi*8 +: 8];
        end
    endgenerate

    // State register; async reset aborts any access in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_state_next;
    end

    // Next-state decode: faults skip straight to the response.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    if (w_fault)                       w_state_next = ST_RESP;
                    else if (!bus.req_store)           w_state_next = ST_LOAD;
                    else if (bus.req_funct3 == 3'b011) w_state_next = ST_WRITE;
                    else                               w_state_next = ST_MERGE;
                end
            end
            ST_LOAD:  w_state_next = ST_RESP;
            ST_MERGE: w_state_next = ST_WRITE;
            ST_WRITE: w_state_next = ST_RESP;
            ST_RESP:  w_state_next = ST_IDLE;
            default:  w_state_next = ST_IDLE;
        endcase
    end

    // Request capture at accept, load result and merged word captured at their edges.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_funct3 <= 3'd0;
            r_addr   <= 64'd0;
            r_wdata  <= 64'd0;
            r_merged <= 64'd0;
            r_rdata  <= 64'd0;
            r_fault  <= 1'b0;
        end else begin
            if (w_accept) begin
                r_funct3 <= bus.req_funct3;
                r_addr   <= bus.req_addr;
                r_wdata  <= bus.req_wdata;
                r_merged <= bus.req_wdata;
                r_rdata  <= 64'd0;
                r_fault  <= w_fault;
            end
            if (r_state == ST_LOAD)  r_rdata  <= w_load_ext;
            if (r_state == ST_MERGE) r_merged <= w_merged;
        end
    end

    assign bus.req_ready  = (r_state == ST_IDLE);
    assign bus.mem_read   = (r_state == ST_LOAD) || (r_state == ST_MERGE);
    assign bus.mem_write  = (r_state == ST_WRITE);
    assign bus.mem_addr   = (bus.mem_read || bus.mem_write) ? {r_addr[63:3], 3'b000} : 64'd0;
    assign bus.mem_wdata  = bus.mem_write ? r_merged : 64'd0;
    assign bus.resp_valid = (r_state == ST_RESP);
    assign bus.resp_rdata = bus.resp_valid ? r_rdata : 64'd0;
    assign bus.resp_fault = bus.resp_valid && r_fault;

`ifdef LSU_FAULT_COUNT_EN
    logic [15:0] r_fault_count;
    // Count faulting responses, sticking at the maximum.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_fault_count <= 16'd0;
        else if (bus.resp_valid && r_fault && (r_fault_count != 16'hFFFF))
            r_fault_count <= r_fault_count + 16'd1;
    end
    assign fault_count = r_fault_count;
`endif

endmodule
